// File: rtl/debug_input_loader_if.sv
// Write-transaction channel from the front-panel loader to the CPU debug logic.
//   valid  : write pending (driven by master)
//   ready  : consumer accepts the write this cycle (driven by slave)
//   target : 00 register1, 01 pc, 10 accumulator, 11 opCode
//   data   : value to write
interface debug_input_loader_if #(
  parameter int unsigned REGISTER_WIDTH = 8
);
  logic                      valid;
  logic                      ready;
  logic [1:0]                target;
  logic [REGISTER_WIDTH-1:0] data;

  modport master (output valid, output target, output data, input ready);
  modport slave  (input valid, input target, input data, output ready);
endinterface

// File: rtl/debug_input_loader.sv
// Front-panel write path into the CPU debug registers. A raw pushbutton is
// synchronised and debounced; each accepted press captures the switch bank and
// target select and presents exactly one write on a valid/ready channel.
// A new write requires a debounced release followed by a debounced press.
// Ports:
//   clock         system clock, rising edge
//   isReset       asynchronous active-low reset
//   button_i      raw pushbutton, active-high, bouncy, asynchronous
//   data_switch_i raw switch bank (value to write)
//   target_i      raw 2-bit target select
//   write_if      master side of the write channel (valid/ready/target/data)
//   press_count_o completed transfers, wraps 255 -> 0
module debug_input_loader #(
  parameter int unsigned REGISTER_WIDTH  = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic                      button_i,
  input  logic [REGISTER_WIDTH-1:0] data_switch_i,
  input  logic [1:0]                target_i,
  debug_input_loader_if.master      write_if,
  output logic [7:0]                press_count_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DEB,
    S_ISSUE,
    S_RELEASE_WAIT,
    S_RELEASE_DEB
  } state_e;

  // Two-stage synchronisers for all raw panel inputs
  logic                      button_meta_q, button_sync_q;
  logic [REGISTER_WIDTH-1:0] data_meta_q, data_sync_q;
  logic [1:0]                target_meta_q, target_sync_q;

  always_ff @(posedge clock or negedge isReset) begin
    if (!isReset) begin
      button_meta_q <= 1'b0;
      button_sync_q <= 1'b0;
      data_meta_q   <= '0;
      data_sync_q   <= '0;
      target_meta_q <= 2'b00;
      target_sync_q <= 2'b00;
    end else begin
      button_meta_q <= button_i;
      button_sync_q <= button_meta_q;
      data_meta_q   <= data_switch_i;
      data_sync_q   <= data_meta_q;
      target_meta_q <= target_i;
      target_sync_q <= target_meta_q;
    end
  end

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      valid_q;
  logic [1:0]                target_q;
  logic [REGISTER_WIDTH-1:0] data_q;
  logic [7:0]                press_count_q;

  // Debounce / issue FSM; all outputs come straight from registers
  always_ff @(posedge clock or negedge isReset) begin
    if (!isReset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      valid_q       <= 1'b0;
      target_q      <= 2'b00;
      data_q        <= '0;
      press_count_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (button_sync_q) begin
            state_q <= S_PRESS_DEB;
            cnt_q   <= '0;
          end
        end
        S_PRESS_DEB: begin
          if (!button_sync_q) begin
            // glitch rejected
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= S_ISSUE;
            data_q   <= data_sync_q;
            target_q <= target_sync_q;
            valid_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          // Button level is ignored here; the release path starts after the transfer
          if (valid_q && write_if.ready) begin
            state_q       <= S_RELEASE_WAIT;
            valid_q       <= 1'b0;
            press_count_q <= press_count_q + 8'd1;
          end
        end
        S_RELEASE_WAIT: begin
          if (!button_sync_q) begin
            state_q <= S_RELEASE_DEB;
            cnt_q   <= '0;
          end
        end
        S_RELEASE_DEB: begin
          if (button_sync_q) begin
            state_q <= S_RELEASE_WAIT;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign write_if.valid  = valid_q;
  assign write_if.target = target_q;
  assign write_if.data   = data_q;
  assign press_count_o   = press_count_q;

endmodule
